// File: rtl/tdm_demux_1x2.sv
// tdm_demux_1x2: receive side of a 2:1 TDM link.
// Splits one multiplexed sample stream back into two held channels.
// Slot 0 goes to y0 and slot 1 goes to y1. Slot position is tracked by a
// sync-locked FSM. The block flags framing errors and counts complete frames.
module tdm_demux_1x2 #(
  parameter int unsigned WIDTH      = 8,
  // 1: frame_sync must accompany every slot-0 sample.
  // 0: frame_sync is only needed to acquire lock.
  parameter bit          SYNC_EVERY = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic             y0_stb,
  output logic             y1_stb,
  output logic             frame_valid,
  output logic             locked,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  // StS1 means a slot-0 sample is held and the next sample is slot 1.
  // StS0 means the block is locked and the next sample is slot 0.
  typedef enum logic [1:0] {
    StHunt = 2'b00,
    StS0   = 2'b01,
    StS1   = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] y0_q, y0_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic             y0_stb_q, y0_stb_d;
  logic             y1_stb_q, y1_stb_d;
  logic             frame_valid_q, frame_valid_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Next-state and output decode. Only cycles with a valid sample advance the FSM.
  // Pulses default low, so they never last longer than one cycle.
  always_comb begin
    state_d       = state_q;
    y0_d          = y0_q;
    y1_d          = y1_q;
    y0_stb_d      = 1'b0;
    y1_stb_d      = 1'b0;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          // Samples without sync are dropped silently while hunting.
          if (frame_sync) begin
            y0_d     = din;
            y0_stb_d = 1'b1;
            state_d  = StS1;
          end
        end

        StS1: begin
          if (frame_sync) begin
            // Sync arrived early. Discard the open frame and restart it with this sample.
            sync_err_d = 1'b1;
            y0_d       = din;
            y0_stb_d   = 1'b1;
            state_d    = StS1;
          end else begin
            y1_d          = din;
            y1_stb_d      = 1'b1;
            frame_valid_d = 1'b1;
            frame_cnt_d   = frame_cnt_q + CNT_W'(1);
            state_d       = StS0;
          end
        end

        StS0: begin
          if (frame_sync || !SYNC_EVERY) begin
            y0_d     = din;
            y0_stb_d = 1'b1;
            state_d  = StS1;
          end else begin
            // Sync is missing where it is required. Drop the sample and reacquire lock.
            sync_err_d = 1'b1;
            state_d    = StHunt;
          end
        end

        default: begin
          state_d = StHunt;
        end
      endcase
    end

    locked_d = (state_d != StHunt);
  end

  // State and output registers. The reset is asynchronous and clears every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      y0_q          <= '0;
      y1_q          <= '0;
      y0_stb_q      <= 1'b0;
      y1_stb_q      <= 1'b0;
      frame_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      y0_q          <= y0_d;
      y1_q          <= y1_d;
      y0_stb_q      <= y0_stb_d;
      y1_stb_q      <= y1_stb_d;
      frame_valid_q <= frame_valid_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign y0          = y0_q;
  assign y1          = y1_q;
  assign y0_stb      = y0_stb_q;
  assign y1_stb      = y1_stb_q;
  assign frame_valid = frame_valid_q;
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;
  assign frame_cnt   = frame_cnt_q;

  // A matched pair is always reported together with its slot-1 update.
  frame_valid_needs_y1: assert property (@(posedge clk) disable iff (!rst_n)
    frame_valid |-> y1_stb);

endmodule
